// File: rtl/sim_run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and helpers for the simulation run controller.
//   run_state_e  : controller FSM states
//   run_status_e : end-of-run status code driven on sim_run_ctrl.status
//   popcount32 / lowest_set32 : channel-vector helpers (vectors zero-extended to 32 bits)
package run_ctrl_pkg;

  localparam int STATUS_W = 3;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } run_state_e;

  typedef enum logic [STATUS_W-1:0] {
    NONE    = 3'd0,
    PASS    = 3'd1,
    TIMEOUT = 3'd2,
    ERR_MON = 3'd3,
    ERR_MEM = 3'd4,
    STALL   = 3'd5
  } run_status_e;

  function automatic int popcount32(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n = n + int'(v[i]);
    return n;
  endfunction

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int lowest_set32(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) if (v[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/sim_run_ctrl_sat_counter.sv
// sat_counter: W-bit accumulator that saturates at all-ones.
//   clk, rst : clock, async active-high reset (clears q)
//   clr      : synchronous clear, wins over en
//   en       : add 'add' to q this cycle
//   add      : increment amount
//   q        : current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] add,
  output logic [W-1:0] q
);

  logic [W:0] sum;
  assign sum = {1'b0, q} + {1'b0, add};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= sum[W] ? '1 : sum[W-1:0];
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: bench run controller. Sequences the DUT reset, then supervises
// the run: halt channels, timeout, monitor/memory errors and a commit-progress
// watchdog. Ends in a sticky done with a status code.
//   clk, rst     : clock, async active-high reset (restarts the whole sequence)
//   timeout_cyc  : RUN-cycle budget, captured on entry to RUN (0 = off)
//   stall_limit  : max consecutive RUN cycles without any commit (0 = off)
//   halt, commit : per-channel halt seen / commit valid
//   mon_error, mem_error : error flags
//   dut_rst      : reset to DUT
//   running      : in RUN
//   done, status : sticky end-of-run and run_status_e code
//   halt_ch      : lowest halting channel (meaningful when status == PASS)
//   cycle_cnt    : RUN cycles elapsed (saturating)
//   commit_cnt   : total commit bits seen in RUN (saturating)
module sim_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int RST_CYCLES   = 2,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 5,
  localparam int HCH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CNT_W-1:0]    timeout_cyc,
  input  logic [CNT_W-1:0]    stall_limit,
  input  logic [NUM_CH-1:0]   halt,
  input  logic [NUM_CH-1:0]   commit,
  input  logic                mon_error,
  input  logic                mem_error,
  output logic                dut_rst,
  output logic                running,
  output logic                done,
  output logic [STATUS_W-1:0] status,
  output logic [HCH_W-1:0]    halt_ch,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    commit_cnt
);

  localparam int HOLD_W  = $clog2(RST_CYCLES + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  run_state_e          state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [STATUS_W-1:0] status_d;
  logic [HCH_W-1:0]    halt_ch_d;

  logic [CNT_W-1:0]    stall_q, stall_nxt, commit_add;
  logic                in_run, any_commit, stall_hit, tmo_hit;

  assign in_run     = (state_q == RUN);
  assign any_commit = |commit;
  assign commit_add = CNT_W'(popcount32(32'(commit)));

  // Stall length including this cycle; compared before the counter updates
  // so the limit trips on the cycle that reaches it.
  assign stall_nxt = (&stall_q) ? stall_q : stall_q + 1'b1;
  assign stall_hit = (stall_limit != '0) && !any_commit && (stall_nxt >= stall_limit);

  // rem_q is 0 when the timeout is disabled, so reaching 1 only happens when armed.
  assign tmo_hit = (rem_q == CNT_W'(1));

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst(rst), .clr(1'b0), .en(in_run), .add(CNT_W'(1)), .q(cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_commit_cnt (
    .clk(clk), .rst(rst), .clr(1'b0), .en(in_run), .add(commit_add), .q(commit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .clr(in_run && any_commit), .en(in_run), .add(CNT_W'(1)),
    .q(stall_q)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    drain_d   = drain_q;
    rem_d     = rem_q;
    status_d  = status;
    halt_ch_d = halt_ch;
    unique case (state_q)
      RST_HOLD: begin
        if (hold_q == HOLD_W'(RST_CYCLES - 1)) begin
          state_d = RUN;
          rem_d   = timeout_cyc;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        if (rem_q != '0) rem_d = rem_q - 1'b1;
        if (|halt) begin
          state_d   = DONE;
          status_d  = PASS;
          halt_ch_d = HCH_W'(lowest_set32(32'(halt)));
        end else if (tmo_hit) begin
          state_d  = DONE;
          status_d = TIMEOUT;
        end else if (mon_error || mem_error) begin
          state_d  = DRAIN;
          status_d = mon_error ? ERR_MON : ERR_MEM;
          drain_d  = '0;
        end else if (stall_hit) begin
          state_d  = DRAIN;
          status_d = STALL;
          drain_d  = '0;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) state_d = DONE;
        else                                       drain_d = drain_q + 1'b1;
      end
      DONE:    state_d = DONE;
      default: state_d = RST_HOLD;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_HOLD;
      hold_q  <= '0;
      drain_q <= '0;
      rem_q   <= '0;
      status  <= NONE;
      halt_ch <= '0;
      dut_rst <= 1'b1;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      drain_q <= drain_d;
      rem_q   <= rem_d;
      status  <= status_d;
      halt_ch <= halt_ch_d;
      dut_rst <= (state_d == RST_HOLD);
      running <= (state_d == RUN);
      done    <= (state_d == DONE);
    end
  end

endmodule
